// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I multi-cycle controller: opcodes, ALU/branch
// encodings, writeback-source codes, FSM states and instruction classes.
package rv32i_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // ALU operations, encoded as {funct7[5], funct3}
    localparam logic [3:0] ADD  = 4'b0000;
    localparam logic [3:0] SUB  = 4'b1000;
    localparam logic [3:0] SLL  = 4'b0001;
    localparam logic [3:0] SLT  = 4'b0010;
    localparam logic [3:0] SLTU = 4'b0011;
    localparam logic [3:0] XOR  = 4'b0100;
    localparam logic [3:0] SRL  = 4'b0101;
    localparam logic [3:0] SRA  = 4'b1101;
    localparam logic [3:0] OR   = 4'b0110;
    localparam logic [3:0] AND  = 4'b0111;

    // Branch conditions, encoded as funct3
    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    localparam logic [2:0] WSEL_ALU    = 3'd0;
    localparam logic [2:0] WSEL_MEM    = 3'd1;
    localparam logic [2:0] WSEL_IMM    = 3'd2;
    localparam logic [2:0] WSEL_PC_IMM = 3'd3;
    localparam logic [2:0] WSEL_PC4    = 3'd4;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WB,
        TRAP
    } state_t;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_LUI,
        CLS_AUIPC,
        CLS_JAL,
        CLS_JALR,
        CLS_NONE
    } instr_class_t;

    // Unsupported funct7/funct3 combinations fall back to ADD.
    function automatic logic [3:0] alu_encode(input logic [3:0] sel);
        case (sel)
            ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND: return sel;
            default: return ADD;
        endcase
    endfunction

    function automatic logic [3:0] branch_encode(input logic [2:0] funct3);
        case (funct3)
            BEQ, BNE, BLT, BGE, BLTU, BGEU: return {1'b0, funct3};
            default: return ADD;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// Combinational instruction decode: opcode/funct fields to legality, class and
// the per-instruction datapath selects used during EXECUTE.
module rv32i_decoder
    import rv32i_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic         funct7_b5,
    output logic         legal,
    output instr_class_t instr_class,
    output logic [3:0]   alu_controls,
    output logic         alu_src,
    output logic [2:0]   wdata_sel
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        legal        = 1'b1;
        instr_class  = CLS_NONE;
        alu_controls = ADD;
        alu_src      = 1'b0;
        wdata_sel    = WSEL_ALU;

        case (opcode)
            OP_R: begin
                instr_class  = CLS_R;
                alu_controls = alu_encode({funct7_b5, funct3});
            end
            OP_I: begin
                // Only SRAI carries a meaningful funct7[5]; elsewhere it is immediate data.
                instr_class  = CLS_I;
                alu_src      = 1'b1;
                alu_controls = alu_encode({(funct3 == 3'b101) ? funct7_b5 : 1'b0, funct3});
            end
            OP_LOAD: begin
                instr_class = CLS_LOAD;
                alu_src     = 1'b1;
            end
            OP_STORE: begin
                instr_class = CLS_STORE;
                alu_src     = 1'b1;
            end
            OP_BRANCH: begin
                instr_class  = CLS_BRANCH;
                alu_controls = branch_encode(funct3);
            end
            OP_LUI: begin
                instr_class = CLS_LUI;
                wdata_sel   = WSEL_IMM;
            end
            OP_AUIPC: begin
                instr_class = CLS_AUIPC;
                wdata_sel   = WSEL_PC_IMM;
            end
            OP_JAL: begin
                instr_class = CLS_JAL;
                wdata_sel   = WSEL_PC4;
            end
            OP_JALR: begin
                instr_class = CLS_JALR;
                wdata_sel   = WSEL_PC4;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv32i_mc_controller.sv
// Multi-cycle RV32I sequencer: owns the instruction register and steps each
// instruction through FETCH/DECODE/EXECUTE[/MEM[/WB]] with handshaked memories.
module rv32i_mc_controller
    import rv32i_pkg::*;
#(
    parameter logic [31:0] IR_RESET = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] imem_rdata,
    output logic        i_req,
    input  logic        i_ack,
    output logic        d_req,
    output logic        d_we,
    output logic [1:0]  d_size,
    input  logic        d_ack,
    output logic [31:0] instr_code,
    output logic        pc_en,
    output logic        reg_wr_en,
    output logic        aluSrcMuxSel,
    output logic [2:0]  RegWdataSel,
    output logic [3:0]  alu_controls,
    output logic        branch,
    output logic        JAL,
    output logic        JAIR,
    output logic        retire,
    output logic        illegal
);

    state_t       state;
    state_t       state_next;
    logic [31:0]  ir;
    logic         started;
    logic         fetch_done;

    logic         dec_legal;
    instr_class_t dec_class;
    logic [3:0]   dec_alu;
    logic         dec_alu_src;
    logic [2:0]   dec_wsel;

    rv32i_decoder u_decoder (
        .opcode       (ir[6:0]),
        .funct3       (ir[14:12]),
        .funct7_b5    (ir[30]),
        .legal        (dec_legal),
        .instr_class  (dec_class),
        .alu_controls (dec_alu),
        .alu_src      (dec_alu_src),
        .wdata_sel    (dec_wsel)
    );

    // The first cycle after reset is dead so no request leaves before the
    // memories have also come out of reset.
    assign fetch_done = (state == FETCH) && started && i_ack;

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state   <= FETCH;
            ir      <= IR_RESET;
            started <= 1'b0;
        end else begin
            state   <= state_next;
            started <= 1'b1;
            if (fetch_done) begin
                ir <= imem_rdata;
            end
        end
    end

    assign instr_code = ir;
    assign d_size     = ir[13:12];

    always_comb begin
        state_next   = state;
        i_req        = 1'b0;
        d_req        = 1'b0;
        d_we         = 1'b0;
        pc_en        = 1'b0;
        reg_wr_en    = 1'b0;
        aluSrcMuxSel = 1'b0;
        RegWdataSel  = WSEL_ALU;
        alu_controls = ADD;
        branch       = 1'b0;
        JAL          = 1'b0;
        JAIR         = 1'b0;
        retire       = 1'b0;
        illegal      = 1'b0;

        case (state)
            FETCH: begin
                i_req = started;
                if (fetch_done) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                state_next = dec_legal ? EXECUTE : TRAP;
            end
            EXECUTE: begin
                aluSrcMuxSel = dec_alu_src;
                alu_controls = dec_alu;
                RegWdataSel  = dec_wsel;
                state_next   = FETCH;
                case (dec_class)
                    CLS_R, CLS_I, CLS_LUI, CLS_AUIPC: begin
                        reg_wr_en = 1'b1;
                        pc_en     = 1'b1;
                        retire    = 1'b1;
                    end
                    CLS_BRANCH: begin
                        branch = 1'b1;
                        pc_en  = 1'b1;
                        retire = 1'b1;
                    end
                    CLS_JAL, CLS_JALR: begin
                        JAL       = 1'b1;
                        JAIR      = (dec_class == CLS_JALR);
                        reg_wr_en = 1'b1;
                        pc_en     = 1'b1;
                        retire    = 1'b1;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        state_next = MEM;
                    end
                    default: begin
                        state_next = TRAP;
                    end
                endcase
            end
            MEM: begin
                // A store completes on the ack cycle itself, so the commit
                // strobes follow d_ack directly.
                d_req = 1'b1;
                d_we  = (dec_class == CLS_STORE);
                if (d_ack) begin
                    if (dec_class == CLS_STORE) begin
                        pc_en      = 1'b1;
                        retire     = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = WB;
                    end
                end
            end
            WB: begin
                reg_wr_en   = 1'b1;
                RegWdataSel = WSEL_MEM;
                pc_en       = 1'b1;
                retire      = 1'b1;
                state_next  = FETCH;
            end
            TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

endmodule
